// File: rtl/fifo_pkg.sv
// Shared types for the show-ahead FIFO packet reader.
//   rd_state_t : reader FSM state
//   rd_beat_t  : one output-stream beat (payload word plus framing flags)
package fifo_pkg;

    localparam int unsigned BEAT_DATA_W = 8;

    typedef enum logic {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   first;
        logic                   last;
    } rd_beat_t;

endpackage

// File: rtl/pkt_skid_buffer.sv
// Two-entry valid/ready register slice carrying rd_beat_t.
//   clock, reset_n : clock and synchronous active-low reset
//   in_valid       : push in_beat this cycle (only legal while can_accept)
//   in_beat        : beat to enqueue
//   can_accept     : registered; room for one more beat this cycle
//   out_valid      : out_beat holds a valid beat
//   out_beat       : head beat, stable until out_ready
//   out_ready      : downstream takes out_beat when out_valid && out_ready
module pkt_skid_buffer
    import fifo_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     in_valid,
    input  rd_beat_t in_beat,
    output logic     can_accept,
    output logic     out_valid,
    output rd_beat_t out_beat,
    input  logic     out_ready
);

    rd_beat_t out_q, out_d;
    rd_beat_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     can_accept_q, can_accept_d;
    logic     deq;

    // Head slot refills from the skid slot first so order is preserved.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        deq          = out_valid_q && out_ready;

        if (!out_valid_q || deq) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = in_valid;
                if (in_valid) begin
                    skid_d = in_beat;
                end
            end else begin
                out_valid_d = in_valid;
                if (in_valid) begin
                    out_d = in_beat;
                end
            end
        end else if (in_valid) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end

        // Registered so the upstream pop never sees out_ready combinationally.
        can_accept_d = !(out_valid_d && skid_valid_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            can_accept_q <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            can_accept_q <= can_accept_d;
        end
    end

    assign can_accept = can_accept_q;
    assign out_valid  = out_valid_q;
    assign out_beat   = out_q;

endmodule

// File: rtl/fifo_packet_reader.sv
// Drains length-prefixed packets from a show-ahead FIFO and re-emits the
// payload on a valid/ready stream with first/last framing.
//   clock, reset_n   : clock and synchronous active-low reset
//   fifo_data        : FIFO head word, valid while fifo_valid
//   fifo_valid       : FIFO non-empty
//   fifo_read_enable : pop the head word this cycle
//   m_data/m_valid   : payload stream, m_ready is the downstream accept
//   m_first/m_last   : first / last payload word of a packet
//   pkt_done         : one-cycle pulse after the last payload word is popped
//   len_err          : sticky, an oversize header length was seen
//   busy             : reader is inside a packet payload
module fifo_packet_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = BEAT_DATA_W,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  pkt_done,
    output logic                  len_err,
    output logic                  busy
);

    localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 1);

    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             first_pending_q, first_pending_d;
    logic             len_err_q, len_err_d;
    logic             pkt_done_q, pkt_done_d;

    logic             pop_c;
    logic             push_c;
    logic             can_accept;
    logic [LEN_W-1:0] hdr_len;
    rd_beat_t         in_beat;
    rd_beat_t         out_beat;

    assign hdr_len = fifo_data[LEN_W-1:0];

    // Pop is held off during reset so an aborted packet's FIFO words stay put.
    assign pop_c = reset_n && fifo_valid && ((state_q == ST_HDR) || can_accept);

    // Header parse and payload counting.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        first_pending_d = first_pending_q;
        len_err_d       = len_err_q;
        pkt_done_d      = 1'b0;
        push_c          = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (pop_c) begin
                    if (hdr_len == '0) begin
                        state_d = ST_HDR;
                    end else if (hdr_len > LEN_W'(MAX_PKT_LEN)) begin
                        len_err_d = 1'b1;
                    end else begin
                        remaining_d     = hdr_len;
                        first_pending_d = 1'b1;
                        state_d         = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (pop_c) begin
                    push_c          = 1'b1;
                    first_pending_d = 1'b0;
                    remaining_d     = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        pkt_done_d = 1'b1;
                        state_d    = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_HDR;
            remaining_q     <= '0;
            first_pending_q <= 1'b0;
            len_err_q       <= 1'b0;
            pkt_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            first_pending_q <= first_pending_d;
            len_err_q       <= len_err_d;
            pkt_done_q      <= pkt_done_d;
        end
    end

    always_comb begin
        in_beat       = '0;
        in_beat.data  = fifo_data;
        in_beat.first = first_pending_q;
        in_beat.last  = (remaining_q == LEN_W'(1));
    end

    pkt_skid_buffer u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (push_c),
        .in_beat    (in_beat),
        .can_accept (can_accept),
        .out_valid  (m_valid),
        .out_beat   (out_beat),
        .out_ready  (m_ready)
    );

    assign fifo_read_enable = pop_c;
    assign m_data           = out_beat.data;
    assign m_first          = out_beat.first;
    assign m_last           = out_beat.last;
    assign pkt_done         = pkt_done_q;
    assign len_err          = len_err_q;
    assign busy             = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_fifo_packet_reader.sv
module tb_fifo_packet_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_read_enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_first;
    logic       m_last;
    logic       pkt_done;
    logic       len_err;
    logic       busy;

    always #5 clock = ~clock;

    fifo_packet_reader dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .fifo_data        (fifo_data),
        .fifo_valid       (fifo_valid),
        .fifo_read_enable (fifo_read_enable),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_first          (m_first),
        .m_last           (m_last),
        .pkt_done         (pkt_done),
        .len_err          (len_err),
        .busy             (busy)
    );

    typedef struct {
        logic [7:0] d;
        bit         f;
        bit         l;
    } beat_t;

    typedef struct {
        logic [7:0] hdr;
        int         beats;
        bit         err;
        int         done;
    } vec_t;

    logic [7:0] fq[$];
    beat_t      exq[$];
    vec_t       vt[8];

    int   tests, fails;
    int   pop_cnt, done_cnt, beat_cnt, cyc;
    int   first_pop_cyc, last_pop_cyc;
    bit   gate, rdy, rnd;
    bit   stall_prev;
    logic [9:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        pop_cnt       = 0;
        done_cnt      = 0;
        beat_cnt      = 0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    // One clock: drive at negedge, sample #1 later, account at posedge.
    task automatic cycle();
        bit         pop;
        bit         hs;
        logic [9:0] got;
        beat_t      e;
        if (rnd) begin
            gate = ($urandom_range(3) != 0);
            rdy  = ($urandom_range(9) < 7);
        end
        fifo_valid = gate && (fq.size() != 0);
        fifo_data  = fifo_valid ? fq[0] : 8'h00;
        m_ready    = rdy;
        #1;
        if (stall_prev) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'({m_data, m_first, m_last}), 32'(held));
        end
        if (!fifo_valid) check("no_pop_when_empty", 32'(fifo_read_enable), 32'd0);
        pop        = (fifo_read_enable === 1'b1);
        hs         = (m_valid === 1'b1) && (m_ready === 1'b1);
        got        = {m_data, m_first, m_last};
        stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
        held       = got;
        @(posedge clock);
        cyc++;
        if (pop) begin
            void'(fq.pop_front());
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (hs) begin
            beat_cnt++;
            if (exq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h expected no beat", got);
            end else begin
                e = exq.pop_front();
                check("beat", 32'(got), 32'({e.d, e.f, e.l}));
            end
        end
        @(negedge clock);
        if (pkt_done === 1'b1) done_cnt++;
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while ((exq.size() != 0 || fq.size() != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        if (n >= max_cyc) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exq.size() + fq.size());
            fq.delete();
            exq.delete();
        end
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gate    = 1'b0;
        rdy     = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic push_payload(input int n);
        logic [7:0] w;
        for (int k = 0; k < n; k++) begin
            w = 8'($urandom);
            fq.push_back(w);
            exq.push_back('{d: w, f: (k == 0), l: (k == n - 1)});
        end
    endtask

    initial begin
        int         n;
        int         exp_done;
        bit         exp_err;
        int         exp_beats;
        int         len;
        logic [7:0] hdr;

        tests = 0; fails = 0; cyc = 0;
        rnd = 1'b0; stall_prev = 1'b0;
        fifo_valid = 1'b0; fifo_data = 8'h00; m_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        do_reset();
        check("reset_outputs",
              32'({fifo_read_enable, m_valid, m_data, m_first, m_last, pkt_done, len_err, busy}), 32'd0);

        // {header, expected beats, expected len_err (sticky), expected pkt_done}
        vt[0] = '{hdr: 8'h03, beats: 3,  err: 1'b0, done: 1};
        vt[1] = '{hdr: 8'h00, beats: 0,  err: 1'b0, done: 0};
        vt[2] = '{hdr: 8'h01, beats: 1,  err: 1'b0, done: 1};
        vt[3] = '{hdr: 8'h10, beats: 16, err: 1'b0, done: 1};
        vt[4] = '{hdr: 8'hE2, beats: 2,  err: 1'b0, done: 1};
        vt[5] = '{hdr: 8'h11, beats: 0,  err: 1'b1, done: 0};
        vt[6] = '{hdr: 8'h02, beats: 2,  err: 1'b1, done: 1};
        vt[7] = '{hdr: 8'h3F, beats: 0,  err: 1'b1, done: 0};

        gate = 1'b1;
        rdy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_counts();
            fq.push_back(vt[i].hdr);
            push_payload(vt[i].beats);
            drain(100, "table");
            check($sformatf("tbl%0d_beats", i), 32'(beat_cnt), 32'(vt[i].beats));
            check($sformatf("tbl%0d_done", i), 32'(done_cnt), 32'(vt[i].done));
            check($sformatf("tbl%0d_len_err", i), 32'(len_err), 32'(vt[i].err));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_pop_span", i), 32'(last_pop_cyc - first_pop_cyc), 32'(vt[i].beats));
        end

        // Downstream stall right after the first accepted beat.
        do_reset();
        clear_counts();
        gate = 1'b1;
        rdy  = 1'b1;
        fq.push_back(8'h04);
        push_payload(4);
        n = 0;
        while (beat_cnt < 1 && n < 50) begin cycle(); n++; end
        check("stall_first_beat_seen", 32'(beat_cnt), 32'd1);
        rdy = 1'b0;
        repeat (5) cycle();
        check("stall_pop_limit", 32'(pop_cnt <= 4), 32'd1);
        check("stall_valid_held", 32'(m_valid), 32'd1);
        rdy = 1'b1;
        drain(100, "stall");
        check("stall_beats", 32'(beat_cnt), 32'd4);
        check("stall_done", 32'(done_cnt), 32'd1);

        // FIFO runs dry after two payload words.
        clear_counts();
        fq.push_back(8'h04);
        push_payload(4);
        n = 0;
        while (pop_cnt < 3 && n < 50) begin cycle(); n++; end
        check("gap_popped", 32'(pop_cnt), 32'd3);
        gate = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("gap_busy", 32'(busy), 32'd1);
        end
        check("gap_no_pops", 32'(pop_cnt), 32'd3);
        gate = 1'b1;
        drain(100, "gap");
        check("gap_beats", 32'(beat_cnt), 32'd4);
        check("gap_done", 32'(done_cnt), 32'd1);
        check("gap_busy_end", 32'(busy), 32'd0);

        // Reset during payload word 2; leftover words become headers afterwards.
        clear_counts();
        fq.push_back(8'h04);
        fq.push_back(8'h11);
        fq.push_back(8'h00);
        fq.push_back(8'h00);
        fq.push_back(8'h01);
        fq.push_back(8'h77);
        exq.push_back('{d: 8'h11, f: 1'b1, l: 1'b0});
        n = 0;
        while (pop_cnt < 2 && n < 50) begin cycle(); n++; end
        reset_n = 1'b0;
        cycle();
        check("midpkt_reset_outputs",
              32'({fifo_read_enable, m_valid, m_data, m_first, m_last, pkt_done, len_err, busy}), 32'd0);
        check("midpkt_reset_fifo_kept", 32'(fq.size()), 32'd4);
        reset_n = 1'b1;
        exq.push_back('{d: 8'h77, f: 1'b1, l: 1'b1});
        drain(100, "midpkt");
        check("midpkt_beats", 32'(beat_cnt), 32'd2);
        check("midpkt_done", 32'(done_cnt), 32'd1);

        // Random packets, random FIFO gaps and back-pressure against a stream model.
        do_reset();
        clear_counts();
        exp_done  = 0;
        exp_err   = 1'b0;
        exp_beats = 0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(20);
            hdr = 8'(($urandom_range(7) * 32) + len);
            fq.push_back(hdr);
            len = hdr % 32;
            if (len > 16) begin
                exp_err = 1'b1;
            end else if (len != 0) begin
                push_payload(len);
                exp_done++;
                exp_beats += len;
            end
        end
        rnd = 1'b1;
        drain(5000, "random");
        rnd = 1'b0;
        check("rand_beats", 32'(beat_cnt), 32'(exp_beats));
        check("rand_done", 32'(done_cnt), 32'(exp_done));
        check("rand_len_err", 32'(len_err), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
